// File: rtl/ldm_stm_seq_pkg.sv
// ldm_stm_seq_pkg
//   Shared constants and types for the LDM/STM block-transfer sequencer:
//   address-calculator function codes, sequencer state encoding and the
//   default word stride / register-list width.
package ldm_stm_seq_pkg;

  // Byte stride between consecutive transferred registers.
  localparam int WORD_BYTES = 4;

  // One bit per architectural register.
  localparam int LIST_W = 16;

  // Address-calculator function codes for multiple transfers.
  typedef enum logic [2:0] {
    MULTIPLE_PRE_SUB  = 3'b100,
    MULTIPLE_PRE_ADD  = 3'b101,
    MULTIPLE_POST_SUB = 3'b110,
    MULTIPLE_POST_ADD = 3'b111
  } calc_func_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ldm_stm_seq_reg_list_scan.sv
// reg_list_scan
//   Purely combinational helper that inspects a register list.
//   Ports:
//     list        in   register list, one bit per register
//     low_idx     out  index of the lowest set bit (0 when list is empty)
//     clear_mask  out  one-hot mask of that lowest set bit (0 when empty)
//     count       out  number of set bits
//     empty       out  1 when no bit is set
module reg_list_scan #(
  parameter  int LIST_W = 16,
  localparam int IDX_W  = $clog2(LIST_W),
  localparam int CNT_W  = $clog2(LIST_W + 1)
) (
  input  logic [LIST_W-1:0] list,
  output logic [IDX_W-1:0]  low_idx,
  output logic [LIST_W-1:0] clear_mask,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  // Two's-complement trick isolates the lowest set bit.
  assign clear_mask = list & (~list + LIST_W'(1));
  assign empty      = (list == '0);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < LIST_W; i++) begin
      count = count + CNT_W'(list[i]);
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq
//   Block-transfer sequencer for LDM/STM. Accepts a decoded multiple-transfer
//   instruction, walks its register list lowest register first (one beat per
//   cycle), drives the address calculator's multiple-transfer controls and the
//   register-file index, then issues an optional base-writeback beat.
//   Ports:
//     clk_in, reset_in                      clock, synchronous active-high reset
//     start_in                              decoded LDM/STM valid (sampled in IDLE)
//     reg_list_in, rn_in                    register list, base register index
//     load_in, up_in, pre_in, wb_in         L, U, P, W instruction bits
//     stall_in                              memory not ready: hold current beat
//     busy_out                              sequencer active / pipeline hold
//     ldm_stm_en_out, ldm_stm_start_out     calculator multiple mode, first beat
//     func_out, offset_out                  calculator function and offset
//     reg_idx_out, reg_valid_out            register index and beat valid
//     is_load_out                           latched load bit
//     wb_en_out                             base-writeback beat
//     done_out                              one-cycle completion pulse
module ldm_stm_seq #(
  parameter  int WORD_BYTES = ldm_stm_seq_pkg::WORD_BYTES,
  parameter  int LIST_W     = ldm_stm_seq_pkg::LIST_W,
  localparam int IDX_W      = $clog2(LIST_W),
  localparam int CNT_W      = $clog2(LIST_W + 1)
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [LIST_W-1:0] reg_list_in,
  input  logic [IDX_W-1:0]  rn_in,
  input  logic              load_in,
  input  logic              up_in,
  input  logic              pre_in,
  input  logic              wb_in,
  input  logic              stall_in,
  output logic              busy_out,
  output logic              ldm_stm_en_out,
  output logic              ldm_stm_start_out,
  output logic [2:0]        func_out,
  output logic [31:0]       offset_out,
  output logic [IDX_W-1:0]  reg_idx_out,
  output logic              reg_valid_out,
  output logic              is_load_out,
  output logic              wb_en_out,
  output logic              done_out
);

  import ldm_stm_seq_pkg::*;

  seq_state_t        state_reg, state_next;
  logic [LIST_W-1:0] list_reg;   // registers not yet transferred
  logic [CNT_W-1:0]  k_reg;      // beats completed so far
  logic              load_reg;
  logic              up_reg;
  logic              pre_reg;
  logic              wb_reg;     // writeback requested and not suppressed

  logic [LIST_W-1:0] scan_list;
  logic [IDX_W-1:0]  scan_idx;
  logic [LIST_W-1:0] scan_clear;
  logic [CNT_W-1:0]  scan_count;
  logic              scan_empty;

  logic [CNT_W-1:0]  words;      // offset in words
  logic [CNT_W-1:0]  beat_words;
  logic              last_beat;

  // In IDLE the scanner looks at the incoming list (empty-list detection);
  // otherwise it looks at what remains of the latched list.
  assign scan_list = (state_reg == IDLE) ? reg_list_in : list_reg;

  reg_list_scan #(.LIST_W(LIST_W)) u_scan (
    .list       (scan_list),
    .low_idx    (scan_idx),
    .clear_mask (scan_clear),
    .count      (scan_count),
    .empty      (scan_empty)
  );

  // N never needs storing: N = k + remaining, so N - k is just the popcount
  // of the remaining list, and k equals N once every beat has completed.
  always_comb begin
    unique case ({up_reg, pre_reg})
      2'b10:   beat_words = k_reg;                       // IA
      2'b11:   beat_words = k_reg + CNT_W'(1);           // IB
      2'b00:   beat_words = scan_count - CNT_W'(1);      // DA
      default: beat_words = scan_count;                  // DB
    endcase
  end

  assign last_beat   = (scan_count == CNT_W'(1));
  assign offset_out  = 32'(words) * 32'(WORD_BYTES);
  assign is_load_out = load_reg;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      list_reg <= '0;
      k_reg    <= '0;
      load_reg <= 1'b0;
      up_reg   <= 1'b0;
      pre_reg  <= 1'b0;
      wb_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start_in) begin
            list_reg <= reg_list_in;
            k_reg    <= '0;
            load_reg <= load_in;
            up_reg   <= up_in;
            pre_reg  <= pre_in;
            // A load that overwrites the base register wins over writeback.
            wb_reg   <= wb_in && !(load_in && reg_list_in[rn_in]);
          end
        end
        XFER: begin
          if (!stall_in) begin
            list_reg <= list_reg & ~scan_clear;
            k_reg    <= k_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next        = state_reg;
    busy_out          = 1'b0;
    ldm_stm_en_out    = 1'b0;
    ldm_stm_start_out = 1'b0;
    func_out          = 3'b000;
    words             = '0;
    reg_idx_out       = '0;
    reg_valid_out     = 1'b0;
    wb_en_out         = 1'b0;
    done_out          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start_in) begin
          state_next = scan_empty ? DONE : XFER;
        end
      end
      XFER: begin
        busy_out          = 1'b1;
        ldm_stm_en_out    = 1'b1;
        ldm_stm_start_out = (k_reg == '0);
        func_out          = up_reg ? MULTIPLE_PRE_ADD : MULTIPLE_PRE_SUB;
        words             = beat_words;
        reg_idx_out       = scan_idx;
        reg_valid_out     = 1'b1;
        if (!stall_in && last_beat) begin
          state_next = wb_reg ? WB : DONE;
        end
      end
      WB: begin
        busy_out       = 1'b1;
        ldm_stm_en_out = 1'b1;
        func_out       = up_reg ? MULTIPLE_PRE_ADD : MULTIPLE_PRE_SUB;
        words          = k_reg;
        wb_en_out      = 1'b1;
        if (!stall_in) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq
//   Self-checking bench for ldm_stm_seq. Expected beats are derived from the
//   memory picture of a block transfer: the lowest register sits at the lowest
//   address, each beat's offset is the distance of its address from the base.
module tb_ldm_stm_seq;

  logic        clk_in = 1'b0;
  logic        reset_in, start_in, load_in, up_in, pre_in, wb_in, stall_in;
  logic [15:0] reg_list_in;
  logic [3:0]  rn_in;
  logic        busy_out, ldm_stm_en_out, ldm_stm_start_out, reg_valid_out;
  logic        is_load_out, wb_en_out, done_out;
  logic [2:0]  func_out;
  logic [31:0] offset_out;
  logic [3:0]  reg_idx_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  ldm_stm_seq dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .start_in          (start_in),
    .reg_list_in       (reg_list_in),
    .rn_in             (rn_in),
    .load_in           (load_in),
    .up_in             (up_in),
    .pre_in            (pre_in),
    .wb_in             (wb_in),
    .stall_in          (stall_in),
    .busy_out          (busy_out),
    .ldm_stm_en_out    (ldm_stm_en_out),
    .ldm_stm_start_out (ldm_stm_start_out),
    .func_out          (func_out),
    .offset_out        (offset_out),
    .reg_idx_out       (reg_idx_out),
    .reg_valid_out     (reg_valid_out),
    .is_load_out       (is_load_out),
    .wb_en_out         (wb_en_out),
    .done_out          (done_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic junk_fields();
    reg_list_in = 16'($urandom);
    rn_in       = 4'($urandom);
    load_in     = 1'($urandom);
    up_in       = 1'($urandom);
    pre_in      = 1'($urandom);
    wb_in       = 1'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".busy"},  busy_out,          0);
    chk({tag, ".en"},    ldm_stm_en_out,    0);
    chk({tag, ".start"}, ldm_stm_start_out, 0);
    chk({tag, ".valid"}, reg_valid_out,     0);
    chk({tag, ".wben"},  wb_en_out,         0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    chk({tag, ".done"}, done_out,    0);
    chk({tag, ".func"}, func_out,    0);
    chk({tag, ".off"},  offset_out,  0);
    chk({tag, ".idx"},  reg_idx_out, 0);
    chk({tag, ".ld"},   is_load_out, 0);
  endtask

  // Runs one instruction from IDLE (called at a negedge) back to IDLE.
  task automatic run_instr(input string name, input logic [15:0] list, input logic [3:0] rn,
                           input logic ld, input logic up, input logic pre, input logic wb,
                           input int forced_stalls, input int stall_pct);
    int   n, lo, a, k, beats, stalls_seen;
    int   q_idx[$];
    int   q_off[$];
    logic exp_wb, stall;
    logic [2:0] exp_func;

    n = $countones(list);
    // Lowest address of the block relative to the base.
    if (up) lo = pre ? 4 : 0;
    else    lo = pre ? -4 * n : -4 * n + 4;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        a = lo + 4 * k;
        q_idx.push_back(i);
        q_off.push_back(up ? a : -a);
        k++;
      end
    end
    exp_wb   = wb && (n != 0) && !(ld && list[rn]);
    exp_func = up ? 3'b101 : 3'b100;
    beats = 0;
    stalls_seen = 0;

    chk({name, ".pre_busy"}, busy_out, 0);
    reg_list_in = list; rn_in = rn; load_in = ld; up_in = up; pre_in = pre; wb_in = wb;
    start_in = 1'b1; stall_in = 1'b0;
    @(negedge clk_in);

    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        chk($sformatf("%s.b%0d.valid", name, b), reg_valid_out,     1);
        chk($sformatf("%s.b%0d.busy", name, b),  busy_out,          1);
        chk($sformatf("%s.b%0d.en", name, b),    ldm_stm_en_out,    1);
        chk($sformatf("%s.b%0d.start", name, b), ldm_stm_start_out, (b == 0));
        chk($sformatf("%s.b%0d.idx", name, b),   reg_idx_out,       q_idx[b]);
        chk($sformatf("%s.b%0d.off", name, b),   offset_out,        q_off[b]);
        chk($sformatf("%s.b%0d.func", name, b),  func_out,          exp_func);
        chk($sformatf("%s.b%0d.ld", name, b),    is_load_out,       ld);
        chk($sformatf("%s.b%0d.wben", name, b),  wb_en_out,         0);
        chk($sformatf("%s.b%0d.done", name, b),  done_out,          0);
        stall = ((b == 0) && (c < forced_stalls)) ||
                ((c < 3) && ($urandom_range(0, 99) < stall_pct));
        if (stall) stalls_seen++;
        stall_in = stall;
        start_in = 1'($urandom);   // must be ignored while busy
        junk_fields();
        @(negedge clk_in);
        if (!stall) break;
      end
      beats++;
    end

    if (exp_wb) begin
      for (int c = 0; c < 16; c++) begin
        chk({name, ".wb.wben"},  wb_en_out,      1);
        chk({name, ".wb.valid"}, reg_valid_out,  0);
        chk({name, ".wb.en"},    ldm_stm_en_out, 1);
        chk({name, ".wb.busy"},  busy_out,       1);
        chk({name, ".wb.off"},   offset_out,     4 * n);
        chk({name, ".wb.func"},  func_out,       exp_func);
        stall = (c < 3) && ($urandom_range(0, 99) < stall_pct);
        stall_in = stall;
        start_in = 1'($urandom);
        junk_fields();
        @(negedge clk_in);
        if (!stall) break;
      end
    end

    // DONE cycle; a start offered here must be dropped.
    chk({name, ".done"},       done_out,      1);
    chk({name, ".done.busy"},  busy_out,      0);
    chk({name, ".done.valid"}, reg_valid_out, 0);
    chk({name, ".done.wben"},  wb_en_out,     0);
    stall_in = 1'b0;
    start_in = 1'b1;
    junk_fields();
    @(negedge clk_in);
    start_in = 1'b0;
    check_quiet({name, ".after"});
    chk({name, ".after.done"}, done_out, 0);
    $display("instr %-8s list=%04h ld=%0b up=%0b pre=%0b wb=%0b beats=%0d stalls=%0d wb_beat=%0b",
             name, list, ld, up, pre, wb, beats, stalls_seen, exp_wb);
  endtask

  initial begin
    reset_in = 1'b1; start_in = 1'b0; stall_in = 1'b0;
    reg_list_in = '0; rn_in = '0; load_in = 1'b0; up_in = 1'b0; pre_in = 1'b0; wb_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    chk("reset.done", done_out, 0);
    reset_in = 1'b0;
    @(negedge clk_in);

    // Directed cases from the plan.
    run_instr("stm_ia",  16'h000B, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    run_instr("ldm_db",  16'h8001, 4'd13, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr("ldm_ib",  16'h0010, 4'd4,  1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    run_instr("full_da", 16'hFFFF, 4'd13, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    run_instr("stall0",  16'h0006, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
    run_instr("empty",   16'h0000, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1, 0, 0);

    // Reset during beat 2 of an 8-register STM.
    reg_list_in = 16'h00FF; rn_in = 4'd13; load_in = 1'b0; up_in = 1'b1; pre_in = 1'b0; wb_in = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_mid.b2.idx", reg_idx_out, 2);
    chk("rst_mid.b2.off", offset_out,  8);
    reset_in = 1'b1;
    @(negedge clk_in);
    check_all_zero("rst_mid");
    chk("rst_mid.done", done_out, 0);
    reset_in = 1'b0;
    @(negedge clk_in);
    check_quiet("rst_mid.idle");
    $display("instr rst_mid  list=00ff aborted at beat 2");
    run_instr("post_rst", 16'h0A50, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1, 30);

    // Randomized instructions with random stalls.
    for (int t = 0; t < 30; t++) begin
      logic [15:0] l;
      l = 16'($urandom);
      if (t % 7 == 0) l = '0;
      if (t % 5 == 1) l = l & 16'($urandom);
      run_instr($sformatf("rnd%0d", t), l, 4'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 0, 25);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
